// File: rtl/lsu_mem_unit.sv
`default_nettype none
// ============================================================================
// lsu_mem_unit : single-outstanding load/store unit with alignment checks,
//                byte-lane steering and a load-response timeout.
// Revision     : 1.0
// ============================================================================
module lsu_mem_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_zero_ext,
    input  logic [1:0]  in_size,
    input  logic [31:0] in_base,
    input  logic [11:0] in_imm,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_is_load,
    output logic        out_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_next;
    logic             is_load, zero_ext;
    logic [1:0]       size;
    logic [31:0]      ea, store_data;
    logic [CNT_W-1:0] cnt;

    logic [31:0] ea_in;
    logic        illegal_in;
    logic        accept;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign ea_in  = in_base + {{20{in_imm[11]}}, in_imm};
    assign accept = in_valid && in_ready;

    always_comb begin
        case (in_size)
            2'b00:   illegal_in = 1'b0;
            2'b01:   illegal_in = ea_in[0];
            2'b10:   illegal_in = (ea_in[1:0] != 2'b00);
            default: illegal_in = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)        state_next = illegal_in ? DONE : REQ;
            REQ:  if (mem_req_ready) state_next = is_load ? WAIT : DONE;
            WAIT: if (mem_rsp_valid || cnt == CNT_LIMIT) state_next = DONE;
            DONE: if (out_ready)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Right-justify the addressed lane, then extend to the access width.
    assign shifted = mem_rdata >> {ea[1:0], 3'b000};
    always_comb begin
        case (size)
            2'b00:   load_val = zero_ext ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
            2'b01:   load_val = zero_ext ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_load     <= 1'b0;
            zero_ext    <= 1'b0;
            size        <= 2'b00;
            ea          <= 32'd0;
            store_data  <= 32'd0;
            cnt         <= '0;
            out_rd      <= 5'd0;
            out_is_load <= 1'b0;
            out_data    <= 32'd0;
            out_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    is_load     <= in_is_load;
                    zero_ext    <= in_zero_ext;
                    size        <= in_size;
                    ea          <= ea_in;
                    store_data  <= in_store_data;
                    out_rd      <= in_is_load ? in_rd : 5'd0;
                    out_is_load <= in_is_load;
                    out_data    <= 32'd0;
                    out_err     <= illegal_in;
                end
                REQ: if (mem_req_ready) cnt <= '0;
                WAIT: begin
                    // A response arriving on the timeout cycle takes priority.
                    if (mem_rsp_valid) begin
                        out_data <= load_val;
                        out_err  <= 1'b0;
                    end else if (cnt == CNT_LIMIT) begin
                        out_data <= 32'd0;
                        out_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign mem_req_valid = (state == REQ);

    always_comb begin
        mem_addr  = 32'd0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'd0;
        if (state == REQ) begin
            mem_addr = {ea[31:2], 2'b00};
            mem_we   = !is_load;
            if (!is_load) begin
                case (size)
                    2'b00: begin
                        mem_wstrb = 4'b0001 << ea[1:0];
                        mem_wdata = {4{store_data[7:0]}};
                    end
                    2'b01: begin
                        mem_wstrb = 4'b0011 << ea[1:0];
                        mem_wdata = {2{store_data[15:0]}};
                    end
                    default: begin
                        mem_wstrb = 4'b1111;
                        mem_wdata = store_data;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_unit.sv
`default_nettype none
// ============================================================================
// tb_lsu_mem_unit : directed and randomized checks of lsu_mem_unit against a
//                   behavioural load/store model.
// Revision        : 1.0
// ============================================================================
module tb_lsu_mem_unit;

    localparam int T = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_is_load = 1'b0, in_zero_ext = 1'b0;
    logic [1:0]  in_size = 2'b00;
    logic [31:0] in_base = 32'd0, in_store_data = 32'd0;
    logic [11:0] in_imm = 12'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_ready;
    logic        mem_req_valid, mem_we;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        out_valid, out_is_load, out_err;
    logic        out_ready = 1'b0;
    logic [4:0]  out_rd;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_fails  = 0;

    lsu_mem_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_zero_ext(in_zero_ext), .in_size(in_size),
        .in_base(in_base), .in_imm(in_imm), .in_store_data(in_store_data), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_data(out_data), .out_is_load(out_is_load), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference value a load should return, from lane position and width.
    function automatic logic [31:0] model_load(input int sz, input bit zx, input int lane,
                                              input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * lane);
        if (sz == 0) begin
            v = v % 256;
            if (!zx && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v % 65536;
            if (!zx && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic run_op(input bit ld, input bit zx, input int sz, input logic [31:0] base,
                          input logic [11:0] imm, input logic [31:0] sdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input int req_wait, input int rsp_wait,
                          input int out_wait, input bit tmo);
        int          off, lane, waited;
        logic [31:0] ea, exp_data, exp_strb, exp_wdata;
        bit          bad, exp_err;

        off = int'(imm);
        if (off >= 2048) off = off - 4096;
        ea   = base + off;
        lane = int'(ea % 4);
        bad  = (sz == 3) || (sz == 1 && lane % 2 != 0) || (sz == 2 && lane != 0);
        if (sz == 0)      begin exp_strb = 1 << lane; exp_wdata = (sdata % 256) * 32'h0101_0101; end
        else if (sz == 1) begin exp_strb = 3 << lane; exp_wdata = (sdata % 65536) * 32'h0001_0001; end
        else              begin exp_strb = 15;        exp_wdata = sdata; end
        if (ld) exp_strb = 0;
        exp_err  = bad || (ld && tmo);
        exp_data = (exp_err || !ld) ? 32'd0 : model_load(sz, zx, lane, rdata);

        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_is_load = ld; in_zero_ext = zx; in_size = 2'(sz);
        in_base = base; in_imm = imm; in_store_data = sdata; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0; in_is_load = 1'($urandom); in_size = 2'($urandom);
        in_base = $urandom; in_imm = 12'($urandom); in_store_data = $urandom; in_rd = 5'($urandom);

        if (!bad) begin
            check("req_valid", {31'd0, mem_req_valid}, 32'd1);
            check("mem_addr", mem_addr, ea - 32'(lane));
            check("mem_we", {31'd0, mem_we}, {31'd0, !ld});
            check("mem_wstrb", {28'd0, mem_wstrb}, exp_strb);
            if (!ld) check("mem_wdata", mem_wdata, exp_wdata);
            for (int i = 0; i < req_wait; i++) begin
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'b1; mem_rdata = $urandom;
                @(negedge clk);
                check("req_hold_valid", {31'd0, mem_req_valid}, 32'd1);
                check("req_hold_addr", mem_addr, ea - 32'(lane));
                check("req_hold_strb", {28'd0, mem_wstrb}, exp_strb);
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("req_dropped", {31'd0, mem_req_valid}, 32'd0);
            if (ld && tmo) begin
                waited = 0;
                while (!out_valid && waited < T + 10) begin
                    @(negedge clk);
                    waited++;
                end
                check("timeout_cycles", 32'(waited), 32'(T + 1));
            end else if (ld) begin
                check("wait_no_out", {31'd0, out_valid}, 32'd0);
                repeat (rsp_wait) @(negedge clk);
                mem_rsp_valid = 1'b1; mem_rdata = rdata;
                @(negedge clk);
                mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            end
        end

        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("out_err", {31'd0, out_err}, {31'd0, exp_err});
        check("out_data", out_data, exp_data);
        check("out_rd", {27'd0, out_rd}, ld ? {27'd0, rd} : 32'd0);
        check("out_is_load", {31'd0, out_is_load}, {31'd0, ld});
        if (bad) check("no_req_illegal", {31'd0, mem_req_valid}, 32'd0);
        if (ld && tmo) begin
            mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        end
        for (int i = 0; i < out_wait; i++) begin
            @(negedge clk);
            check("out_hold_valid", {31'd0, out_valid}, 32'd1);
            check("out_hold_data", out_data, exp_data);
            check("out_hold_err", {31'd0, out_err}, {31'd0, exp_err});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; mem_rsp_valid = 1'b0;
        check("out_released", {31'd0, out_valid}, 32'd0);
        check("back_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int sz;
        bit ld, tmo;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // LB, negative offset into top lane
        run_op(1, 0, 0, 32'h1000, 12'hFFF, 0, 5'd3, 32'h80FF_7F00, 0, 0, 0, 0);
        // LHU upper half
        run_op(1, 1, 1, 32'h2002, 12'h000, 0, 5'd7, 32'hBEEF_1234, 0, 0, 2, 0);
        // SB to lane 1
        run_op(0, 0, 0, 32'h3001, 12'h000, 32'h0000_00AB, 5'd9, 0, 0, 0, 0, 0);
        // Misaligned LW
        run_op(1, 0, 2, 32'h4002, 12'h000, 0, 5'd1, 0, 0, 0, 1, 0);
        // LW with stalled request then timeout, late response ignored
        run_op(1, 0, 2, 32'h5000, 12'h000, 0, 5'd4, 32'h1234_5678, 5, 0, 2, 1);
        // Response on the timeout cycle wins
        run_op(1, 0, 2, 32'h6000, 12'h004, 0, 5'd5, 32'hCAFE_F00D, 0, T, 0, 0);
        run_op(0, 0, 1, 32'h7000, 12'h002, 32'h1234_ABCD, 5'd6, 0, 1, 0, 0, 0);
        run_op(0, 0, 2, 32'h8000, 12'h800, 32'h5555_AAAA, 5'd8, 0, 0, 0, 0, 0);
        run_op(1, 0, 3, 32'h9000, 12'h000, 0, 5'd2, 0, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            ld  = 1'($urandom);
            sz  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            tmo = ld && ($urandom_range(0, 9) == 0);
            run_op(ld, 1'($urandom), sz, $urandom, 12'($urandom), $urandom, 5'($urandom),
                   $urandom, $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(0, 3)),
                   $urandom_range(0, 2), tmo);
        end

        // Reset while waiting for a load response
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_size = 2'd2; in_base = 32'hA000;
        in_imm = 12'd0; in_rd = 5'd11; mem_req_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("mid_rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_out", {31'd0, out_valid}, 32'd0);
            check("post_rst_idle", {31'd0, in_ready}, 32'd1);
        end
        run_op(1, 0, 0, 32'hB003, 12'h000, 0, 5'd12, 32'h7F00_0000, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_unit.md
LSU_MEM_UNIT -- requirements
Module: lsu_mem_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles to wait for a load response before flagging an error.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  decoded memory op present; in_ready  out  1  unit can accept.
REQ-005 in_is_load  in  1  load=1/store=0; in_zero_ext  in  1  unsigned load; in_size  in  2  00 byte, 01 half, 10 word.
REQ-006 in_base  in  32  rs1 value; in_imm  in  12  signed offset; in_store_data  in  32  rs2 value; in_rd  in  5  load destination.
REQ-007 mem_req_valid  out  1; mem_req_ready  in  1; mem_addr  out  32  word-aligned address; mem_we  out  1; mem_wstrb  out  4; mem_wdata  out  32.
REQ-008 mem_rsp_valid  in  1  read data valid; mem_rdata  in  32  read word.
REQ-009 out_valid  out  1; out_ready  in  1; out_rd  out  5; out_data  out  32; out_is_load  out  1; out_err  out  1  misaligned/illegal/timeout.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, DONE; in_ready SHALL equal (state==IDLE).
REQ-011 Accept on in_valid&&in_ready: register all inputs, effective address ea = in_base + sign-extended in_imm, modulo 2^32.
REQ-012 Illegal at accept: in_size==11, half with ea[0]==1, or word with ea[1:0]!=00; SHALL go IDLE->DONE with out_err=1, out_data=0, no memory request.
REQ-013 Legal accept SHALL go IDLE->REQ; mem_req_valid SHALL assert the cycle after accept and hold, with stable fields, until mem_req_ready.
REQ-014 mem_addr = {ea[31:2],2'b00}; mem_we = !is_load.
REQ-015 Store wstrb: byte 0001<<ea[1:0]; half 0011<<ea[1:0]; word 1111; loads wstrb=0000.
REQ-016 Store wdata: byte = store_data[7:0] replicated 4x; half = store_data[15:0] replicated 2x; word = store_data.
REQ-017 On request handshake: store SHALL go REQ->DONE with out_data=0, out_rd=0; load SHALL go REQ->WAIT and clear the timeout counter.
REQ-018 In WAIT, mem_rsp_valid SHALL capture: shifted = mem_rdata >> (8*ea[1:0]); byte/half take low 8/16 bits, sign-extended unless zero_ext; word unshifted; go DONE with out_err=0.
REQ-019 In WAIT, the counter SHALL increment each cycle without response; at count==TIMEOUT_CYCLES go DONE with out_err=1, out_data=0.
REQ-020 mem_rsp_valid outside WAIT SHALL be ignored; a response in the same cycle as the timeout SHALL win (no error).
REQ-021 In DONE, out_valid=1 with stable out_* until out_ready; on handshake go IDLE; next op accepted no earlier than the following cycle.
REQ-022 Minimum latency: store accept->out_valid 2 cycles; load 3 cycles with zero-wait memory; misaligned 1 cycle.
REQ-023 out_rd SHALL be registered in_rd for loads, 0 for stores; out_is_load SHALL be registered in_is_load.
REQ-024 At most one operation SHALL be in flight.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, all outputs 0 except in_ready (1 once state is IDLE); mid-operation reset SHALL abandon the op with no out_valid.

Verification
REQ-026 LB, base 0x1000, imm 0xFFF (-1), rdata 0x80FF_7F00 -> mem_addr 0x0FFC, ea[1:0]=11, out_data 0xFFFF_FF80.
REQ-027 LHU, base 0x2002, imm 0, rdata 0xBEEF_1234 -> out_data 0x0000_BEEF, out_err 0.
REQ-028 SB, base 0x3001, store_data 0x0000_00AB -> mem_wstrb 0010, mem_wdata 0xABAB_ABAB, mem_we 1, out_rd 0.
REQ-029 LW, ea 0x4002 -> out_valid next cycle with out_err 1, mem_req_valid never asserted.
REQ-030 LW with mem_req_ready held 0 for 5 cycles, then no response for TIMEOUT_CYCLES -> request held stable, then out_err 1; late response afterwards ignored.
REQ-031 Reset asserted in WAIT, then response arrives -> outputs 0, in_ready 1, no out_valid.
